// File: rtl/adaptive_threshold.sv
// adaptive_threshold
//   Final stage of the adaptive-thresholding pipeline. Once iStart is seen,
//   raster-scans the image (column fastest), reads the original pixel from the
//   image ROM and the local mean from the middle RAM, and writes a binary pixel
//   (0x00 / 0xFF) to the output RAM at one pixel per clock.
//
//   Optional feature macro: ADAPTIVE_THRESHOLD_INVERT_EN
//     defined   -> pixel > t writes 0x00, otherwise 0xFF
//     undefined -> pixel > t writes 0xFF, otherwise 0x00
//
// Ports
//   clock, reset             : sole clock, synchronous active-high reset
//   iStart                   : level start (box_filter.finished)
//   oImageCol/oImageRow      : image ROM read address (S0)
//   iImageData               : ROM data, 1-cycle read latency
//   oMeanCol/oMeanRow        : middle RAM read address (same as image address)
//   iMeanData                : middle RAM data, 1-cycle read latency
//   oResultCol/Row/Data/Wren : output RAM write port (S2)
//   oBusy                    : high in RUN and DRAIN
//   finished                 : high in DONE, held until reset
module adaptive_threshold #(
    parameter int WIDTH_BITS  = 7,
    parameter int HEIGHT_BITS = 7,
    parameter int OFFSET      = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oMeanCol,
    output logic [HEIGHT_BITS-1:0] oMeanRow,
    input  logic [7:0]             iMeanData,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [7:0]             oResultData,
    output logic                   oResultWren,
    output logic                   oBusy,
    output logic                   finished
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic signed [8:0] C_OFF = 9'(OFFSET);

    state_t                 r_state, w_next;
    logic [WIDTH_BITS-1:0]  r_col,    r_s1_col,  r_res_col;
    logic [HEIGHT_BITS-1:0] r_row,    r_s1_row,  r_res_row;
    logic [7:0]             r_res_data;
    logic                   r_drain;
    // r_vld_pipe[0]: S1 holds a live address; r_vld_pipe[1]: S2 write strobe
    logic [1:0]             r_vld_pipe;

    logic                   w_last;
    logic signed [8:0]      w_t;
    logic [7:0]             w_thr;
    logic                   w_gt;
    logic [7:0]             w_px;

    assign w_last = (r_state == S_RUN) && (&r_col) && (&r_row);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iStart)  w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // S1 compare: threshold in 9-bit signed, negative clamps to 0
    // ------------------------------------------------------------------
    always_comb begin
        w_t   = $signed({1'b0, iMeanData}) - C_OFF;
        w_thr = w_t[8] ? 8'd0 : w_t[7:0];
        w_gt  = iImageData > w_thr;
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
        w_px  = w_gt ? 8'h00 : 8'hFF;
`else
        w_px  = w_gt ? 8'hFF : 8'h00;
`endif
    end

    // ------------------------------------------------------------------
    // State, S0 address counter, S1/S2 pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_drain    <= 1'b0;
            r_vld_pipe <= '0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_res_col  <= '0;
            r_res_row  <= '0;
            r_res_data <= '0;
        end else begin
            r_state <= w_next;

            // Address holds on the last pixel so DRAIN/DONE keep it visible.
            if (r_state == S_RUN && !w_last) begin
                r_col <= r_col + 1'b1;
                if (&r_col) r_row <= r_row + 1'b1;
            end

            // Two DRAIN cycles: r_drain marks the second one.
            r_drain <= (r_state == S_DRAIN) && !r_drain;

            r_vld_pipe <= {r_vld_pipe[0], (r_state == S_RUN)};
            r_s1_col   <= r_col;
            r_s1_row   <= r_row;

            if (r_vld_pipe[0]) begin
                r_res_col  <= r_s1_col;
                r_res_row  <= r_s1_row;
                r_res_data <= w_px;
            end
        end
    end

    assign oImageCol   = r_col;
    assign oImageRow   = r_row;
    assign oMeanCol    = r_col;
    assign oMeanRow    = r_row;
    assign oResultCol  = r_res_col;
    assign oResultRow  = r_res_row;
    assign oResultData = r_res_data;
    assign oResultWren = r_vld_pipe[1];
    assign oBusy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign finished    = (r_state == S_DONE);

endmodule

// File: tb/tb_adaptive_threshold.sv
module tb_adaptive_threshold;

    localparam int WB = 7;
    localparam int HB = 7;
    localparam int W  = 1 << WB;
    localparam int H  = 1 << HB;
    localparam int N  = W * H;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iStart = 1'b0;
    logic [WB-1:0] oImageCol, oMeanCol, oResultCol;
    logic [HB-1:0] oImageRow, oMeanRow, oResultRow;
    logic [7:0]    iImageData, iMeanData, oResultData;
    logic          oResultWren, oBusy, finished;

    adaptive_threshold #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(5)) dut (
        .clock(clock), .reset(reset), .iStart(iStart),
        .oImageCol(oImageCol), .oImageRow(oImageRow), .iImageData(iImageData),
        .oMeanCol(oMeanCol), .oMeanRow(oMeanRow), .iMeanData(iMeanData),
        .oResultCol(oResultCol), .oResultRow(oResultRow), .oResultData(oResultData),
        .oResultWren(oResultWren), .oBusy(oBusy), .finished(finished)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WB-1:0] col;
        logic [HB-1:0] row;
        logic [7:0]    data;
    } wr_t;

    wr_t sb_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  mode = 0;  // 0 uniform 100/100, 1 directed table, 2 col+row vs 64
    int  wr_cnt = 0;
    int  first_cyc = -1;
    int  last_cyc = -1;

    // Directed vectors (rom, ram) with hand-computed non-inverted result, OFFSET=5
    localparam int NV = 7;
    int vec_rom [NV] = '{95,  100, 94,  0,   1,   255, 100};
    int vec_ram [NV] = '{100, 100, 100, 3,   3,   255, 100};
    int vec_exp [NV] = '{0,   255, 0,   0,   255, 255, 255};
    // t = 95,95,95,0(clamped),0(clamped),250,95

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int pix_idx(input int c, input int r);
        return r * W + c;
    endfunction

    function automatic logic [7:0] rom_f(input int c, input int r);
        case (mode)
            1:       return 8'(vec_rom[pix_idx(c, r) % NV]);
            2:       return 8'(c + r);
            default: return 8'd100;
        endcase
    endfunction

    function automatic logic [7:0] ram_f(input int c, input int r);
        case (mode)
            1:       return 8'(vec_ram[pix_idx(c, r) % NV]);
            2:       return 8'd64;
            default: return 8'd100;
        endcase
    endfunction

    function automatic logic [7:0] pol(input logic [7:0] d);
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
        return ~d;
`else
        return d;
`endif
    endfunction

    // Expected non-inverted pixel for each mode (hand-derived per mode)
    function automatic logic [7:0] exp_f(input int c, input int r);
        case (mode)
            1:       return 8'(vec_exp[pix_idx(c, r) % NV]);
            2:       return (c + r > 59) ? 8'hFF : 8'h00;  // t = 64-5 = 59
            default: return 8'hFF;                         // 100 > 95
        endcase
    endfunction

    // Synchronous-read ROM/RAM models
    always @(posedge clock) begin
        iImageData <= rom_f(int'(oImageCol), int'(oImageRow));
        iMeanData  <= ram_f(int'(oMeanCol), int'(oMeanRow));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected write per strobe
    always @(negedge clock) begin
        if (oResultWren) begin
            wr_t e;
            if (wr_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            wr_cnt++;
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%0h expected no write (cycle %0d)",
                         oResultCol, oResultRow, oResultData, cyc);
            end else begin
                e = sb_q.pop_front();
                if (oResultCol !== e.col || oResultRow !== e.row || oResultData !== e.data) begin
                    n_fail++;
                    $display("FAIL write: got (%0d,%0d)=%0h expected (%0d,%0d)=%0h (cycle %0d)",
                             oResultCol, oResultRow, oResultData, e.col, e.row, e.data, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_scan();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                sb_q.push_back('{col: WB'(c), row: HB'(r), data: pol(exp_f(c, r))});
    endtask

    // Issues iStart, returns t0 = value of cyc during the first RUN cycle
    task automatic start_scan(output int t0);
        wr_cnt = 0; first_cyc = -1; last_cyc = -1;
        push_scan();
        iStart = 1'b1;
        tick();
        t0 = cyc;
        iStart = 1'b0;
        chk("t0_col", int'(oImageCol), 0);
        chk("t0_row", int'(oImageRow), 0);
        chk("t0_busy", int'(oBusy), 1);
    endtask

    task automatic finish_scan(input string tag, input int t0);
        int lim = 0;
        while (!finished && lim < N + 100) begin
            tick();
            lim++;
        end
        chk({tag, "_finished_cycle"}, cyc, t0 + N + 2);
        chk({tag, "_busy_after"}, int'(oBusy), 0);
        chk({tag, "_write_count"}, wr_cnt, N);
        chk({tag, "_first_write_cycle"}, first_cyc, t0 + 2);
        chk({tag, "_last_write_cycle"}, last_cyc, t0 + N + 1);
        chk({tag, "_queue_left"}, sb_q.size(), 0);
        chk({tag, "_hold_col"}, int'(oImageCol), W - 1);
        chk({tag, "_hold_row"}, int'(oImageRow), H - 1);
        chk({tag, "_last_res_col"}, int'(oResultCol), W - 1);
        chk({tag, "_last_res_row"}, int'(oResultRow), H - 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        int t0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_wren", int'(oResultWren), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_col", int'(oImageCol), 0);
        chk("rst_res_data", int'(oResultData), 0);
        repeat (4) tick();
        chk("idle_busy", int'(oBusy), 0);

        // Uniform 100/100
        mode = 0;
        start_scan(t0);
        finish_scan("uniform", t0);

        // Directed compare/clamp boundaries
        do_reset();
        mode = 1;
        start_scan(t0);
        finish_scan("boundary", t0);

        // Per-pixel pattern for address alignment
        do_reset();
        mode = 2;
        start_scan(t0);
        finish_scan("pattern", t0);

        // Reset mid-scan
        do_reset();
        mode = 0;
        start_scan(t0);
        while (cyc < t0 + 5000) tick();
        reset = 1'b1;
        tick();
        sb_q.delete();
        chk("midrst_wren", int'(oResultWren), 0);
        chk("midrst_finished", int'(finished), 0);
        chk("midrst_busy", int'(oBusy), 0);
        chk("midrst_col", int'(oImageCol), 0);
        repeat (3) tick();
        chk("midrst_wren_hold", int'(oResultWren), 0);
        reset = 1'b0;
        tick();
        start_scan(t0);
        finish_scan("restart", t0);

        // iStart in DONE is ignored
        wr_cnt = 0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (20) tick();
        chk("done_pulse_writes", wr_cnt, 0);
        chk("done_pulse_finished", int'(finished), 1);
        chk("done_pulse_busy", int'(oBusy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
